covariance_accumulator: RTL and testbench

//  Streams per-tick return samples for N_STOCKS instruments, accumulates sums and cross-products

---
 rtl/covariance_accumulator.sv | 189 ++++++++++++++++++
 tb/tb_covariance_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/covariance_accumulator.sv
// covariance_accumulator
// Accumulates per-stock sums and pairwise cross-products over a window of
// 2**LOG_WINDOW signed samples. It then computes the N_STOCKS x N_STOCKS
// covariance matrix one upper-triangle pair per cycle and presents the
// result with a valid/ready handshake.
// Optional build macro: COV_SAT_EN. When it is defined, each covariance is
// saturated to WIDTH bits. When it is undefined, each covariance is
// truncated (two's-complement wrap).
module covariance_accumulator #(
  parameter int WIDTH      = 16,
  parameter int N_STOCKS   = 4,
  parameter int LOG_WINDOW = 4
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic [N_STOCKS-1:0][WIDTH-1:0]                sample_in,
  input  logic                                          sample_valid_in,
  output logic                                          sample_ready_out,
  output logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]  matrix_out,
  output logic                                          matrix_valid_out,
  input  logic                                          matrix_ready_in
);

  localparam int SW    = WIDTH + LOG_WINDOW;       // sum width
  localparam int PW    = 2 * WIDTH + LOG_WINDOW;   // cross-product sum width
  localparam int CW    = 2 * SW;                   // S[i]*S[j] width
  localparam int DW    = CW + 1;                   // difference width
  localparam int NPAIR = N_STOCKS * (N_STOCKS + 1) / 2;
  localparam int IW    = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  localparam logic [IW-1:0]         LAST_IDX  = IW'(N_STOCKS - 1);
  localparam logic [IW-1:0]         IDX_ONE   = IW'(1);
  localparam logic [KW-1:0]         PAIR_ONE  = KW'(1);
  localparam logic [LOG_WINDOW-1:0] COUNT_ONE = LOG_WINDOW'(1);

  typedef enum logic [1:0] {ST_ACCUM, ST_COMPUTE, ST_PRESENT} state_t;

  state_t                                        state_q;
  logic                                          sample_ready_q;
  logic                                          matrix_valid_q;
  logic [LOG_WINDOW-1:0]                         count_q;
  logic [IW-1:0]                                 row_q;
  logic [IW-1:0]                                 col_q;
  logic [KW-1:0]                                 pair_q;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]  matrix_q;

  logic signed [SW-1:0]    s_q [N_STOCKS];
  logic signed [PW-1:0]    p_q [NPAIR];
  logic signed [WIDTH-1:0] x_s [N_STOCKS];

  logic accept;
  logic window_done;
  logic release_mat;

  // sample_ready_q is only ever high in ACCUM, so it alone qualifies acceptance.
  assign accept      = sample_valid_in & sample_ready_q;
  assign window_done = accept & (count_q == '1);
  assign release_mat = matrix_valid_q & matrix_ready_in;

  // Per-stock sums and upper-triangle cross-product sums.
  // Pair (i,j) with i<=j is stored at a flat row-major triangle index.
  for (genvar gi = 0; gi < N_STOCKS; gi++) begin : g_stock
    assign x_s[gi] = $signed(sample_in[gi]);

    // Sum accumulator: cleared when the presented matrix is taken.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        s_q[gi] <= '0;
      end else if (release_mat) begin
        s_q[gi] <= '0;
      end else if (accept) begin
        s_q[gi] <= s_q[gi] + SW'(x_s[gi]);
      end
    end

    for (genvar gj = gi; gj < N_STOCKS; gj++) begin : g_pair
      localparam int K = gi * N_STOCKS - (gi * (gi - 1)) / 2 + (gj - gi);

      // Cross-product accumulator for pair (gi,gj).
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          p_q[K] <= '0;
        end else if (release_mat) begin
          p_q[K] <= '0;
        end else if (accept) begin
          p_q[K] <= p_q[K] + PW'(x_s[gi]) * PW'(x_s[gj]);
        end
      end
    end
  end

  logic signed [SW-1:0]    s_a;
  logic signed [SW-1:0]    s_b;
  logic signed [PW-1:0]    p_sel;
  logic signed [CW-1:0]    corr_prod;
  logic signed [CW-1:0]    corr_shift;
  logic signed [DW-1:0]    diff;
  logic        [WIDTH-1:0] cov_w;
`ifdef COV_SAT_EN
  logic signed [DW-1:0]    cov_full;
  logic [DW-WIDTH:0]       cov_hi;
`endif

  // Covariance of the pair selected by row_q/col_q.
  // The mean correction and the final divide are both floor shifts.
  always_comb begin
    s_a        = s_q[row_q];
    s_b        = s_q[col_q];
    p_sel      = p_q[pair_q];
    corr_prod  = CW'(s_a) * CW'(s_b);
    corr_shift = corr_prod >>> LOG_WINDOW;
    diff       = DW'(p_sel) - DW'(corr_shift);
`ifdef COV_SAT_EN
    cov_full = diff >>> LOG_WINDOW;
    cov_hi   = cov_full[DW-1:WIDTH-1];
    cov_w    = cov_full[WIDTH-1:0];
    if (!((&cov_hi) || (~|cov_hi))) begin
      cov_w = cov_full[DW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    cov_w = WIDTH'(diff >>> LOG_WINDOW);
`endif
  end

  // Control FSM: accumulate a window, walk the triangle, present until taken.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_ACCUM;
      sample_ready_q <= 1'b0;
      matrix_valid_q <= 1'b0;
      count_q        <= '0;
      row_q          <= '0;
      col_q          <= '0;
      pair_q         <= '0;
      matrix_q       <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          sample_ready_q <= 1'b1;
          if (accept) begin
            count_q <= count_q + COUNT_ONE;
          end
          if (window_done) begin
            sample_ready_q <= 1'b0;
            state_q        <= ST_COMPUTE;
            row_q          <= '0;
            col_q          <= '0;
            pair_q         <= '0;
          end
        end
        ST_COMPUTE: begin
          matrix_q[row_q][col_q] <= cov_w;
          matrix_q[col_q][row_q] <= cov_w;
          pair_q                 <= pair_q + PAIR_ONE;
          if (col_q == LAST_IDX) begin
            if (row_q == LAST_IDX) begin
              state_q        <= ST_PRESENT;
              matrix_valid_q <= 1'b1;
            end else begin
              row_q <= row_q + IDX_ONE;
              col_q <= row_q + IDX_ONE;
            end
          end else begin
            col_q <= col_q + IDX_ONE;
          end
        end
        ST_PRESENT: begin
          if (matrix_ready_in) begin
            matrix_valid_q <= 1'b0;
            sample_ready_q <= 1'b1;
            count_q        <= '0;
            state_q        <= ST_ACCUM;
          end
        end
        default: begin
          state_q        <= ST_ACCUM;
          sample_ready_q <= 1'b0;
          matrix_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sample_ready_out = sample_ready_q;
  assign matrix_valid_out = matrix_valid_q;
  assign matrix_out       = matrix_q;

endmodule

// File: tb/tb_covariance_accumulator.sv
// Testbench for covariance_accumulator: directed and random windows are
// checked against a plain-arithmetic covariance model (honours COV_SAT_EN).
module tb_covariance_accumulator;

  logic                         clk_in;
  logic                         rst_in;
  logic [3:0][15:0]             sample_in;
  logic                         sample_valid_in;
  logic                         sample_ready_out;
  logic [3:0][3:0][15:0]        matrix_out;
  logic                         matrix_valid_out;
  logic                         matrix_ready_in;

  covariance_accumulator #(.WIDTH(16), .N_STOCKS(4), .LOG_WINDOW(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .matrix_out      (matrix_out),
    .matrix_valid_out(matrix_valid_out),
    .matrix_ready_in (matrix_ready_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  logic signed [15:0]    win [16][4];
  logic [3:0][3:0][15:0] exp_m;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic signed [15:0] gen(input int kind, input int n, input int k);
    logic signed [15:0] b;
    case (kind)
      0: gen = 16'sd100;
      1: begin
        b = (n % 2 == 0) ? 16'sd8 : -16'sd8;
        gen = (k == 0 || k == 1) ? b : (k == 2) ? -b : 16'sd0;
      end
      2: gen = (k != 0) ? 16'sd0 : (n % 2 == 0) ? 16'sd32767 : -16'sd32767;
      3: gen = 16'($urandom);
      default: gen = 16'($signed($urandom_range(0, 200)) - 100);
    endcase
  endfunction

  // Covariance from the window with plain integer arithmetic.
  task automatic compute_expected();
    longint s [4];
    longint p, c;
    for (int i = 0; i < 4; i++) begin
      s[i] = 0;
      for (int n = 0; n < 16; n++) s[i] += longint'(win[n][i]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        p = 0;
        for (int n = 0; n < 16; n++) p += longint'(win[n][i]) * longint'(win[n][j]);
        c = (p - ((s[i] * s[j]) >>> 4)) >>> 4;
`ifdef COV_SAT_EN
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
`endif
        exp_m[i][j] = c[15:0];
      end
    end
  endtask

  // Offer num samples (optionally with idle gaps) and record what was accepted.
  task automatic send_window(input int kind, input bit gaps, input int num);
    int n = 0;
    int guard = 0;
    bit acc;
    logic signed [15:0] cur [4];
    while (n < num && guard < 1000) begin
      for (int k = 0; k < 4; k++) begin
        cur[k] = gen(kind, n, k);
        sample_in[k] = cur[k];
      end
      sample_valid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc = sample_valid_in && sample_ready_out;
      tick();
      if (acc) begin
        for (int k = 0; k < 4; k++) win[n][k] = cur[k];
        n++;
      end
      guard++;
    end
    sample_valid_in = 1'b0;
    check("window_accept_count", 256'(n), 256'(num));
  endtask

  task automatic wait_valid(input string tag);
    int lat = 0;
    while (matrix_valid_out !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), 256'd10);
    $display("window %s: matrix valid after %0d edges, m00=%0h m01=%0h", tag, lat,
             matrix_out[0][0], matrix_out[0][1]);
  endtask

  task automatic check_matrix(input string tag);
    compute_expected();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_m%0d%0d", tag, i, j), 256'(matrix_out[i][j]), 256'(exp_m[i][j]));
  endtask

  task automatic consume(input string tag);
    matrix_ready_in = 1'b1;
    tick();
    matrix_ready_in = 1'b0;
    check({tag, "_valid_drop"}, 256'(matrix_valid_out), 256'd0);
    check({tag, "_ready_back"}, 256'(sample_ready_out), 256'd1);
  endtask

  initial begin
    rst_in = 1'b1;
    sample_in = '0;
    sample_valid_in = 1'b0;
    matrix_ready_in = 1'b0;
    repeat (3) tick();
    check("rst_ready", 256'(sample_ready_out), 256'd0);
    check("rst_valid", 256'(matrix_valid_out), 256'd0);
    check("rst_matrix", 256'(matrix_out), 256'd0);
    rst_in = 1'b0;
    #1;
    check("rel_ready_low", 256'(sample_ready_out), 256'd0);
    tick();
    check("rel_ready_high", 256'(sample_ready_out), 256'd1);

    // Constant samples: zero covariance.
    send_window(0, 1'b0, 16);
    wait_valid("const");
    check_matrix("const");
    consume("const");

    // Correlated pattern with idle gaps.
    send_window(1, 1'b1, 16);
    wait_valid("corr");
    check_matrix("corr");
    check("corr_c00", 256'(matrix_out[0][0]), 256'h0040);
    check("corr_c01", 256'(matrix_out[0][1]), 256'h0040);
    check("corr_c21", 256'(matrix_out[2][1]), 256'hFFC0);
    check("corr_c30", 256'(matrix_out[3][0]), 256'h0000);

    // Backpressure: offered samples while presenting must be ignored.
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 4; k++) sample_in[k] = 16'($urandom);
      sample_valid_in = 1'b1;
      tick();
      check("bp_valid", 256'(matrix_valid_out), 256'd1);
      check("bp_ready", 256'(sample_ready_out), 256'd0);
      check("bp_matrix", 256'(matrix_out), 256'(exp_m));
    end
    sample_valid_in = 1'b0;
    consume("bp");
    check("hold_after_consume", 256'(matrix_out), 256'(exp_m));

    // Large swing in stock 0 only.
    send_window(2, 1'b0, 16);
    wait_valid("sat");
    check_matrix("sat");
`ifdef COV_SAT_EN
    check("sat_c00", 256'(matrix_out[0][0]), 256'h7FFF);
`else
    check("sat_c00", 256'(matrix_out[0][0]), 256'h0001);
`endif
    consume("sat");

    // Back-to-back windows with the consumer always ready.
    matrix_ready_in = 1'b1;
    send_window(3, 1'b0, 16);
    wait_valid("b2b1");
    check_matrix("b2b1");
    send_window(4, 1'b1, 16);
    wait_valid("b2b2");
    check_matrix("b2b2");
    tick();
    matrix_ready_in = 1'b0;
    check("b2b_ready_back", 256'(sample_ready_out), 256'd1);

    // Reset in the middle of a window.
    send_window(3, 1'b0, 7);
    rst_in = 1'b1;
    #1;
    check("mid_rst_ready", 256'(sample_ready_out), 256'd0);
    check("mid_rst_valid", 256'(matrix_valid_out), 256'd0);
    check("mid_rst_matrix", 256'(matrix_out), 256'd0);
    repeat (3) tick();
    rst_in = 1'b0;
    #1;
    check("mid_rel_ready_low", 256'(sample_ready_out), 256'd0);
    tick();
    check("mid_rel_ready_high", 256'(sample_ready_out), 256'd1);
    send_window(4, 1'b0, 16);
    wait_valid("after_rst");
    check_matrix("after_rst");
    consume("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
